// File: rtl/dvp_frame_gate_if.sv
// Pixel-stream and status bundle between the DVP capture side and dvp_frame_gate.
// DVP_FRAME_GATE_TESTPAT_EN adds the test_pat select.
interface dvp_frame_gate_if #(
    parameter int unsigned DATA_W = 32
);
    logic              enable;
    logic              in_vsync;
    logic              in_hs;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
`ifdef DVP_FRAME_GATE_TESTPAT_EN
    logic              test_pat;
`endif
    logic              out_load;
    logic              out_wren;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       frame_cnt;
    logic [7:0]        err_cnt;
    logic              active;

    modport master (
`ifdef DVP_FRAME_GATE_TESTPAT_EN
        output test_pat,
`endif
        output enable, in_vsync, in_hs, in_valid, in_data,
        input  out_load, out_wren, out_data, frame_cnt, err_cnt, active
    );

    modport slave (
`ifdef DVP_FRAME_GATE_TESTPAT_EN
        input  test_pat,
`endif
        input  enable, in_vsync, in_hs, in_valid, in_data,
        output out_load, out_wren, out_data, frame_cnt, err_cnt, active
    );
endinterface

// File: rtl/dvp_frame_gate.sv
// Gates the DVP pixel stream into the DDR write FIFO: skips settling frames, crops to
// IMAGE_WIDTH x IMAGE_HEIGHT, counts frames. Colour-bar source: DVP_FRAME_GATE_TESTPAT_EN.
module dvp_frame_gate #(
    parameter int unsigned IMAGE_WIDTH  = 1280,
    parameter int unsigned IMAGE_HEIGHT = 720,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned SKIP_FRAMES  = 10
) (
    input logic             clk,
    input logic             reset_n,
    dvp_frame_gate_if.slave dvp
);

    localparam int unsigned XW = $clog2(IMAGE_WIDTH + 1);
    localparam int unsigned YW = $clog2(IMAGE_HEIGHT + 1);
    localparam int unsigned SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [XW-1:0] XMax     = XW'(IMAGE_WIDTH);
    localparam logic [YW-1:0] YMax     = YW'(IMAGE_HEIGHT);
    localparam logic [SW-1:0] SkipLast = SW'(SKIP_FRAMES);

    typedef enum logic [1:0] {StIdle, StSkip, StActive} state_e;

    state_e            state_q, state_d;
    logic              vs_q, hs_q;
    logic [SW-1:0]     skip_q, skip_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              err_q, err_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              load_q, load_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vs_rise, hs_fall;
    logic [DATA_W-1:0] pix;

    assign vs_rise = dvp.in_vsync & ~vs_q;
    assign hs_fall = ~dvp.in_hs & hs_q;

`ifdef DVP_FRAME_GATE_TESTPAT_EN
    logic [2:0] bar_k;

    // bar_k = floor(x * 8 / IMAGE_WIDTH), found by threshold compares instead of a divider
    always_comb begin
        bar_k = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if ((32'(x_q) << 3) >= i * IMAGE_WIDTH) bar_k = 3'(i);
        end
    end

    assign pix = dvp.test_pat ?
                 DATA_W'({8'h00, {8{bar_k[2]}}, {8{bar_k[1]}}, {8{bar_k[0]}}}) : dvp.in_data;
`else
    assign pix = dvp.in_data;
`endif

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        x_d         = x_q;
        y_d         = y_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        load_d      = 1'b0;
        wren_d      = 1'b0;
        data_d      = data_q;

        if (!dvp.enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StSkip;
                    skip_d  = '0;
                end
                StSkip: begin
                    if (vs_rise) begin
                        if (skip_q == SkipLast) begin
                            state_d = StActive;
                            x_d     = '0;
                            y_d     = '0;
                            err_d   = 1'b0;
                            load_d  = 1'b1;
                        end else begin
                            skip_d = skip_q + 1'b1;
                        end
                    end
                end
                StActive: begin
                    // x saturates at IMAGE_WIDTH; a pixel beyond that marks the line overlong
                    if (dvp.in_valid && !vs_rise) begin
                        if (x_q < XMax) begin
                            x_d = x_q + 1'b1;
                            if (y_q < YMax) begin
                                wren_d = 1'b1;
                                data_d = pix;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (hs_fall) begin
                        if (x_d != XMax) err_d = 1'b1;
                        x_d = '0;
                        if (y_q != YMax) y_d = y_q + 1'b1;
                    end
                    // Frame close sees the line just closed above in the same cycle
                    if (vs_rise) begin
                        if ((y_d != YMax) || err_d) begin
                            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end
                        x_d    = '0;
                        y_d    = '0;
                        err_d  = 1'b0;
                        load_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            vs_q        <= 1'b0;
            hs_q        <= 1'b0;
            skip_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            load_q      <= 1'b0;
            wren_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            vs_q        <= dvp.in_vsync;
            hs_q        <= dvp.in_hs;
            skip_q      <= skip_d;
            x_q         <= x_d;
            y_q         <= y_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            load_q      <= load_d;
            wren_q      <= wren_d;
            data_q      <= data_d;
        end
    end

    assign dvp.out_load  = load_q;
    assign dvp.out_wren  = wren_q;
    assign dvp.out_data  = data_q;
    assign dvp.frame_cnt = frame_cnt_q;
    assign dvp.err_cnt   = err_cnt_q;
    assign dvp.active    = (state_q == StActive);

endmodule

// File: tb/tb_dvp_frame_gate.sv
// Randomized bench for dvp_frame_gate: frames are described as line lengths and the expected
// writes, load pulses and counters are derived from frame-level rules.
module tb_dvp_frame_gate;

    localparam int unsigned W    = 8;
    localparam int unsigned H    = 4;
    localparam int unsigned SKIP = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dvp_frame_gate_if #(.DATA_W(32)) dvp ();

    dvp_frame_gate #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .DATA_W      (32),
        .SKIP_FRAMES (SKIP)
    ) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .dvp    (dvp)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] exp_wr[$], obs_wr[$];
    int          exp_ld[$], obs_ld[$];

    // Frame-level reference state
    bit m_en, m_active, m_good, m_pat;
    int m_seen, m_lines, m_frames, m_errs;

    logic [31:0] bars [8] = '{32'h000000, 32'h0000FF, 32'h00FF00, 32'h00FFFF,
                              32'hFF0000, 32'hFF00FF, 32'hFFFF00, 32'hFFFFFF};

    always @(negedge clk) begin
        if (reset_n) begin
            if (dvp.out_wren) obs_wr.push_back({32'(cyc), dvp.out_data});
            if (dvp.out_load) obs_ld.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, " wren"}, dvp.out_wren, 0);
        check_eq({tag, " load"}, dvp.out_load, 0);
        check_eq({tag, " data"}, dvp.out_data, 0);
        check_eq({tag, " frame_cnt"}, dvp.frame_cnt, 0);
        check_eq({tag, " err_cnt"}, dvp.err_cnt, 0);
        check_eq({tag, " active"}, dvp.active, 0);
    endtask

    task automatic drive(input logic vs, input logic hs, input logic valid,
                         input logic [31:0] data);
        dvp.in_vsync = vs;
        dvp.in_hs    = hs;
        dvp.in_valid = valid;
        dvp.in_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start(input bit valid_at_vs);
        if (m_en) begin
            if (m_active) begin
                if (m_lines >= int'(H) && m_good) m_frames = (m_frames + 1) % 65536;
                else if (m_errs < 255) m_errs++;
                exp_ld.push_back(cyc + 1);
            end else if (m_seen == int'(SKIP)) begin
                m_active = 1'b1;
                exp_ld.push_back(cyc + 1);
            end else begin
                m_seen++;
            end
            m_lines = 0;
            m_good  = 1'b1;
        end
        drive(1'b1, 1'b0, valid_at_vs, $urandom);
        drive(1'b1, 1'b0, 1'b0, $urandom);
        drive(1'b0, 1'b0, 1'b0, $urandom);
    endtask

    task automatic line(input int len, input bit gaps, input bit tail);
        logic [31:0] d;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) drive(1'b0, 1'b1, 1'b0, $urandom);
            d = m_pat ? 32'h0 : $urandom;
            if (m_en && m_active && m_lines < int'(H) && i < int'(W))
                exp_wr.push_back({32'(cyc + 1), m_pat ? bars[(i * 8) / int'(W)] : d});
            drive(1'b0, 1'b1, 1'b1, d);
        end
        if (m_en && m_active) begin
            if (len != int'(W)) m_good = 1'b0;
            m_lines++;
        end
        if (tail) begin
            drive(1'b0, 1'b0, 1'b0, $urandom);
            drive(1'b0, 1'b0, 1'b0, $urandom);
        end
    endtask

    task automatic uniform_frame(input int nlines, input int len);
        frame_start(1'b0);
        for (int l = 0; l < nlines; l++) line(len, 1'b0, 1'b1);
    endtask

    task automatic checkpoint(input string tag);
        logic [63:0] e, o;
        int el, ol;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            if (obs_wr.size() == 0) begin
                check_eq({tag, " wr_missing"}, 64'h0, e);
            end else begin
                o = obs_wr.pop_front();
                check_eq({tag, " wr_cycle"}, o[63:32], e[63:32]);
                check_eq({tag, " wr_data"}, o[31:0], e[31:0]);
            end
        end
        check_eq({tag, " wr_extra"}, obs_wr.size(), 0);
        obs_wr.delete();
        while (exp_ld.size() > 0) begin
            el = exp_ld.pop_front();
            ol = (obs_ld.size() > 0) ? obs_ld.pop_front() : -1;
            check_eq({tag, " load_cycle"}, ol, el);
        end
        check_eq({tag, " load_extra"}, obs_ld.size(), 0);
        obs_ld.delete();
        check_eq({tag, " frame_cnt"}, dvp.frame_cnt, m_frames);
        check_eq({tag, " err_cnt"}, dvp.err_cnt, m_errs);
        check_eq({tag, " active"}, dvp.active, m_en && m_active);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl, len;
        bit merge;
        dvp.enable   = 1'b1;
        dvp.in_vsync = 1'b0;
        dvp.in_hs    = 1'b0;
        dvp.in_valid = 1'b1;
        dvp.in_data  = $urandom;
`ifdef DVP_FRAME_GATE_TESTPAT_EN
        dvp.test_pat = 1'b0;
`endif
        repeat (3) begin
            @(posedge clk);
            #1;
            check_quiet("reset");
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_quiet("post_reset");
        m_en = 1'b1; m_active = 1'b0; m_seen = 0; m_pat = 1'b0;
        m_lines = 0; m_good = 1'b1; m_frames = 0; m_errs = 0;
        repeat (3) drive(1'b0, 1'b0, 1'b0, $urandom);

        // Two settling frames, then one good active frame closed by the next vsync
        for (int f = 0; f < 3; f++) uniform_frame(H, W);
        frame_start(1'b0);
        checkpoint("first_frame");

        // Short second line
        line(W, 1'b0, 1'b1);
        line(6, 1'b0, 1'b1);
        line(W, 1'b0, 1'b1);
        line(W, 1'b0, 1'b1);
        frame_start(1'b0);
        checkpoint("short_line");

        // Overlong lines and extra lines
        for (int l = 0; l < 6; l++) line(10, 1'b0, 1'b1);
        frame_start(1'b1);
        checkpoint("overlong");

        // Random frames: odd line counts/lengths, gaps, pixel on vsync, hs_fall on vsync
        for (int f = 0; f < 10; f++) begin
            nl = $urandom_range(3, 6);
            merge = $urandom_range(0, 1);
            for (int l = 0; l < nl; l++) begin
                len = ($urandom_range(0, 3) != 0) ? int'(W) : $urandom_range(5, 11);
                line(len, $urandom_range(0, 1), !(merge && l == nl - 1));
            end
            frame_start($urandom_range(0, 1));
            checkpoint("random");
        end

        // Drop enable after five pixels of an active frame
        line(5, 1'b0, 1'b0);
        dvp.enable = 1'b0;
        m_en = 1'b0; m_active = 1'b0; m_seen = 0;
        drive(1'b0, 1'b1, 1'b1, $urandom);
        @(negedge clk);
        check_eq("drop wren", dvp.out_wren, 0);
        check_eq("drop active", dvp.active, 0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, $urandom);
        uniform_frame(H, W);
        checkpoint("disabled");

        // Re-enable restarts the settling sequence
        dvp.enable = 1'b1;
        m_en = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b0, $urandom);
        for (int f = 0; f < 4; f++) uniform_frame(H, W);
        frame_start(1'b0);
        checkpoint("reenable");

`ifdef DVP_FRAME_GATE_TESTPAT_EN
        dvp.test_pat = 1'b1;
        m_pat = 1'b1;
        for (int l = 0; l < int'(H); l++) line(W, 1'b0, 1'b1);
        dvp.test_pat = 1'b0;
        m_pat = 1'b0;
        frame_start(1'b0);
        checkpoint("test_pattern");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
